// File: rtl/chip_id_pkg.sv
// Shared definitions for the chip-ID reader: default ID width, FSM states
// and the width of the idclk divider counter.
package chip_id_pkg;

    localparam int ID_WIDTH_DEF = 64;

    // Divider counter width; CLK_DIV is limited to 1..255.
    localparam int CLK_DIV_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/chip_id_clkgen.sv
// idclk generator: divides clk so idclk toggles every CLK_DIV clk cycles while
// run is high, and flags the clk cycles that drive idclk rising or falling.
module chip_id_clkgen
    import chip_id_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic idclk,
    output logic rise_en,
    output logic fall_en
);

    localparam logic [CLK_DIV_W-1:0] DIV_LAST = CLK_DIV_W'(CLK_DIV - 1);

    logic [CLK_DIV_W-1:0] div_cnt;
    logic                 terminal;

    // The toggle cycle: idclk flips on the clock edge that ends this cycle.
    assign terminal = run && (div_cnt == DIV_LAST);
    assign rise_en  = terminal && !idclk;
    assign fall_en  = terminal &&  idclk;

    // Divider count and idclk toggle; both park at 0 whenever run is low.
    always_ff @(posedge clk) begin
        if (reset || !run) begin
            div_cnt <= '0;
            idclk   <= 1'b0;
        end else if (terminal) begin
            div_cnt <= '0;
            idclk   <= ~idclk;
        end else begin
            div_cnt <= div_cnt + CLK_DIV_W'(1);
        end
    end

endmodule

// File: rtl/chip_id_shift_st.sv
// Chip-ID reader: parallel-loads the hard block, shifts the ID out LSB first
// on idclk falling strobes, and presents it on an Avalon-ST source that stays
// valid until a rescan is requested.
module chip_id_shift_st
    import chip_id_pkg::*;
#(
    parameter int CLK_DIV  = 2,
    parameter int ID_WIDTH = ID_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                reset,
    output logic                coe_idclk,
    output logic                coe_shiftnld,
    input  logic                coe_regout,
    input  logic                coe_rescan,
    output logic [ID_WIDTH-1:0] aso_out0_data,
    output logic                aso_out0_valid,
    input  logic                aso_out0_ready
);

    localparam int                CNT_W    = $clog2(ID_WIDTH + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ID_WIDTH - 1);

    state_t              state;
    logic [CNT_W-1:0]    bit_cnt;
    logic [ID_WIDTH-1:0] capture;
    logic [ID_WIDTH-1:0] capture_next;
    logic                run;
    logic                rise_en;
    logic                fall_en;
    logic                ready_unused;

    // The ID never changes, so the source ignores backpressure.
    assign ready_unused = aso_out0_ready;

    assign run          = (state == LOAD) || (state == SHIFT);
    assign capture_next = {coe_regout, capture[ID_WIDTH-1:1]};

    chip_id_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .clk     (clk),
        .reset   (reset),
        .run     (run),
        .idclk   (coe_idclk),
        .rise_en (rise_en),
        .fall_en (fall_en)
    );

    // Read sequencer: load edge, ID_WIDTH-1 shift edges, then hold the result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            bit_cnt        <= '0;
            capture        <= '0;
            coe_shiftnld   <= 1'b0;
            aso_out0_data  <= '0;
            aso_out0_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bit_cnt      <= '0;
                    coe_shiftnld <= 1'b0;
                    state        <= LOAD;
                end
                LOAD: begin
                    // Falling edge after the single load edge: bit 0 is on regout.
                    if (fall_en) begin
                        capture      <= capture_next;
                        bit_cnt      <= CNT_W'(1);
                        coe_shiftnld <= 1'b1;
                        state        <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (fall_en) begin
                        capture <= capture_next;
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        if (bit_cnt == CNT_LAST) begin
                            aso_out0_data  <= capture_next;
                            aso_out0_valid <= 1'b1;
                            coe_shiftnld   <= 1'b0;
                            state          <= DONE;
                        end
                    end
                end
                DONE: begin
                    // Old data stays visible until the next read completes.
                    if (coe_rescan) begin
                        aso_out0_valid <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
